// File: rtl/c432_ack_pkg.sv
// Shared types and constants for the c432 interrupt-acknowledge decoder.
package c432_ack_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILTER,
      ST_REQ,
      ST_ACK,
      ST_WAIT_CLR
   } state_t;

   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_A    = 2'd1;
   localparam logic [1:0] BUS_B    = 2'd2;
   localparam logic [1:0] BUS_C    = 2'd3;

   localparam int NUM_CHAN = 9;
   localparam int VEC_W    = 6;

   typedef struct packed {
      logic [1:0] bus;
      logic [3:0] chan;
   } sample_t;

   // Fixed priority: A over B over C.
   function automatic logic [1:0] bus_sel(input logic pa, input logic pb, input logic pc);
      if (pa)      return BUS_A;
      else if (pb) return BUS_B;
      else if (pc) return BUS_C;
      else         return BUS_NONE;
   endfunction

endpackage

// File: rtl/c432_ack_onehot.sv
// 4-bit channel code to 9-bit one-hot, with a flag for codes past the last channel.
module c432_ack_onehot
   import c432_ack_pkg::*;
(
   input  logic [3:0]          code,
   output logic [NUM_CHAN-1:0] onehot,
   output logic                invalid
);

   always_comb begin
      invalid = (code >= 4'(NUM_CHAN));
      for (int i = 0; i < NUM_CHAN; i++)
         onehot[i] = (code == 4'(i));
   end

endmodule

// File: rtl/c432_ack_decoder.sv
// Filters the controller's bus/channel code, raises a CPU irq, and returns a
// one-hot ack pulse to the winning source; flags invalid codes and stuck requests.
module c432_ack_decoder
   import c432_ack_pkg::*;
#(
   parameter int STABLE_CYCLES = 2,
   parameter int ACK_CYCLES    = 2,
   parameter int TIMEOUT       = 255
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pa,
   input  logic                pb,
   input  logic                pc,
   input  logic [3:0]          chan,
   output logic                irq_o,
   output logic [VEC_W-1:0]    irq_vec_o,
   input  logic                irq_ack_i,
   output logic [NUM_CHAN-1:0] ack_a_o,
   output logic [NUM_CHAN-1:0] ack_b_o,
   output logic [NUM_CHAN-1:0] ack_c_o,
   output logic                err_o,
   input  logic                err_clr_i,
   output logic                busy_o
);

   state_t  state_q, state_d;
   sample_t smp_q, cand_q, cand_d, lat_q, lat_d;
   logic [3:0] scnt_q, scnt_d;
   logic [3:0] acnt_q, acnt_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic       err_set;

   logic [3:0]          dec_code;
   logic [NUM_CHAN-1:0] dec_oh;
   logic                dec_inv;

   // The decoder checks the live sample while filtering, otherwise the latched code.
   assign dec_code = (state_q == ST_FILTER) ? smp_q.chan : lat_q.chan;

   c432_ack_onehot u_onehot (
      .code    (dec_code),
      .onehot  (dec_oh),
      .invalid (dec_inv)
   );

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      lat_d   = lat_q;
      scnt_d  = scnt_q;
      acnt_d  = acnt_q;
      tcnt_d  = tcnt_q;
      err_set = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (smp_q.bus != BUS_NONE) begin
               state_d = ST_FILTER;
               cand_d  = smp_q;
               scnt_d  = '0;
            end
         end
         ST_FILTER: begin
            if (smp_q.bus == BUS_NONE) begin
               state_d = ST_IDLE;
            end else if (smp_q == cand_q) begin
               scnt_d = scnt_q + 4'd1;
               if (int'(scnt_q) + 1 >= STABLE_CYCLES) begin
                  if (dec_inv) begin
                     err_set = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     lat_d   = smp_q;
                     state_d = ST_REQ;
                  end
               end
            end else begin
               cand_d = smp_q;
               scnt_d = '0;
            end
         end
         ST_REQ: begin
            if (irq_ack_i) begin
               state_d = ST_ACK;
               acnt_d  = '0;
            end
         end
         ST_ACK: begin
            acnt_d = acnt_q + 4'd1;
            if (int'(acnt_q) + 1 >= ACK_CYCLES) begin
               state_d = ST_WAIT_CLR;
               tcnt_d  = '0;
            end
         end
         ST_WAIT_CLR: begin
            if (smp_q.bus == BUS_NONE || smp_q != lat_q) begin
               state_d = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
               if (int'(tcnt_q) + 1 >= TIMEOUT) begin
                  err_set = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         smp_q   <= '0;
         cand_q  <= '0;
         lat_q   <= '0;
         scnt_q  <= '0;
         acnt_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         smp_q   <= '{bus: bus_sel(pa, pb, pc), chan: chan};
         cand_q  <= cand_d;
         lat_q   <= lat_d;
         scnt_q  <= scnt_d;
         acnt_q  <= acnt_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_o     <= 1'b0;
         irq_vec_o <= '0;
         ack_a_o   <= '0;
         ack_b_o   <= '0;
         ack_c_o   <= '0;
         err_o     <= 1'b0;
         busy_o    <= 1'b0;
      end else begin
         irq_o     <= (state_d == ST_REQ);
         irq_vec_o <= (state_d == ST_REQ) ? lat_d : '0;
         ack_a_o   <= (state_d == ST_ACK && lat_d.bus == BUS_A) ? dec_oh : '0;
         ack_b_o   <= (state_d == ST_ACK && lat_d.bus == BUS_B) ? dec_oh : '0;
         ack_c_o   <= (state_d == ST_ACK && lat_d.bus == BUS_C) ? dec_oh : '0;
         busy_o    <= (state_d != ST_IDLE);
         if (err_set)        err_o <= 1'b1;
         else if (err_clr_i) err_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_c432_ack_decoder.sv
// Directed and randomized checks of c432_ack_decoder against a behavioural model.
module tb_c432_ack_decoder;

   localparam int STABLE = 2;
   localparam int AC     = 2;
   localparam int TO     = 255;

   logic clk = 1'b0, rst_n = 1'b0;
   logic pa = 1'b0, pb = 1'b0, pc = 1'b0, irq_ack = 1'b0, err_clr = 1'b0;
   logic [3:0] chan = 4'd0;
   logic       irq_o, err_o, busy_o;
   logic [5:0] irq_vec_o;
   logic [8:0] ack_a_o, ack_b_o, ack_c_o;

   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   c432_ack_decoder #(.STABLE_CYCLES(STABLE), .ACK_CYCLES(AC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
      .irq_o(irq_o), .irq_vec_o(irq_vec_o), .irq_ack_i(irq_ack),
      .ack_a_o(ack_a_o), .ack_b_o(ack_b_o), .ack_c_o(ack_c_o),
      .err_o(err_o), .err_clr_i(err_clr), .busy_o(busy_o)
   );

   // Behavioural model: phase of the handshake plus a generic run counter.
   localparam int P_IDLE = 0, P_FILT = 1, P_REQ = 2, P_ACK = 3, P_WAIT = 4;
   int         ph, run;
   logic [1:0] s_bus, c_bus, l_bus;
   logic [3:0] s_chan, c_chan, l_chan;
   logic       set;
   logic       e_irq, e_err, e_busy;
   logic [5:0] e_vec;
   logic [8:0] e_ack [1:3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = P_IDLE; run = 0; s_bus = 0; s_chan = 0; c_bus = 0; c_chan = 0;
         l_bus = 0; l_chan = 0; e_err = 0;
      end else begin
         set = 0;
         case (ph)
            P_IDLE: if (s_bus != 0) begin ph = P_FILT; c_bus = s_bus; c_chan = s_chan; run = 0; end
            P_FILT: begin
               if (s_bus == 0) ph = P_IDLE;
               else if (s_bus == c_bus && s_chan == c_chan) begin
                  run++;
                  if (run == STABLE) begin
                     if (s_chan <= 8) begin l_bus = s_bus; l_chan = s_chan; ph = P_REQ; end
                     else begin set = 1; ph = P_IDLE; end
                  end
               end else begin c_bus = s_bus; c_chan = s_chan; run = 0; end
            end
            P_REQ: if (irq_ack) begin ph = P_ACK; run = 0; end
            P_ACK: begin run++; if (run == AC) begin ph = P_WAIT; run = 0; end end
            P_WAIT: begin
               if (s_bus == 0 || s_bus != l_bus || s_chan != l_chan) ph = P_IDLE;
               else begin run++; if (run == TO) begin set = 1; ph = P_IDLE; end end
            end
            default: ph = P_IDLE;
         endcase
         if (set) e_err = 1;
         else if (err_clr) e_err = 0;
         s_bus  = pa ? 2'd1 : pb ? 2'd2 : pc ? 2'd3 : 2'd0;
         s_chan = chan;
      end
      e_irq  = (ph == P_REQ);
      e_busy = (ph != P_IDLE);
      e_vec  = (ph == P_REQ) ? {l_bus, l_chan} : 6'd0;
      for (int b = 1; b <= 3; b++)
         e_ack[b] = (ph == P_ACK && l_bus == 2'(b)) ? (9'd1 << l_chan) : 9'd0;
   end

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".irq"},   9'(irq_o),     9'(e_irq));
      chk({tag, ".vec"},   9'(irq_vec_o), 9'(e_vec));
      chk({tag, ".ack_a"}, ack_a_o,       e_ack[1]);
      chk({tag, ".ack_b"}, ack_b_o,       e_ack[2]);
      chk({tag, ".ack_c"}, ack_c_o,       e_ack[3]);
      chk({tag, ".err"},   9'(err_o),     9'(e_err));
      chk({tag, ".busy"},  9'(busy_o),    9'(e_busy));
   endtask

   task automatic cyc(input int n, input string tag);
      repeat (n) begin
         @(negedge clk);
         chk_all(tag);
      end
   endtask

   initial begin
      int hold;
      cyc(2, "reset");
      chk("rst_irq", 9'(irq_o), 9'd0);
      chk("rst_busy", 9'(busy_o), 9'd0);
      rst_n = 1'b1;
      cyc(2, "idle");

      // Bus A, channel 5
      pa = 1; chan = 4'd5;
      cyc(3, "t1");
      chk("t1_irq_early", 9'(irq_o), 9'd0);
      cyc(1, "t1");
      chk("t1_irq", 9'(irq_o), 9'd1);
      chk("t1_vec", 9'(irq_vec_o), 9'b01_0101);
      cyc(1, "t1");
      irq_ack = 1;
      cyc(1, "t1");
      irq_ack = 0;
      chk("t1_ack0", ack_a_o, 9'h020);
      chk("t1_irq_low", 9'(irq_o), 9'd0);
      cyc(1, "t1");
      chk("t1_ack1", ack_a_o, 9'h020);
      cyc(1, "t1");
      chk("t1_ack_end", ack_a_o, 9'h000);
      pa = 0;
      cyc(2, "t1");
      chk("t1_busy", 9'(busy_o), 9'd0);

      // Bus B with chattering channel
      pb = 1;
      for (int i = 0; i < 6; i++) begin
         chan = (i % 2) ? 4'd4 : 4'd3;
         cyc(1, "t2");
         chk("t2_noirq", 9'(irq_o), 9'd0);
      end
      cyc(2, "t2");
      chk("t2_irq_early", 9'(irq_o), 9'd0);
      cyc(1, "t2");
      chk("t2_irq", 9'(irq_o), 9'd1);
      chk("t2_vec", 9'(irq_vec_o), 9'b10_0100);
      irq_ack = 1;
      cyc(1, "t2");
      irq_ack = 0; pb = 0;
      chk("t2_ack", ack_b_o, 9'h010);
      cyc(6, "t2");

      // Bus C, invalid channel
      pc = 1; chan = 4'd12;
      cyc(8, "t3");
      chk("t3_err", 9'(err_o), 9'd1);
      chk("t3_noirq", 9'(irq_o), 9'd0);
      chk("t3_noack", ack_c_o, 9'd0);
      pc = 0;
      cyc(3, "t3");
      err_clr = 1;
      cyc(1, "t3");
      err_clr = 0;
      chk("t3_clr", 9'(err_o), 9'd0);

      // A and B together, then a stuck source
      pa = 1; pb = 1; chan = 4'd0;
      cyc(4, "t4");
      chk("t4_vec", 9'(irq_vec_o), 9'b01_0000);
      irq_ack = 1;
      cyc(1, "t4");
      irq_ack = 0;
      chk("t4_ack_a", ack_a_o, 9'h001);
      chk("t4_ack_b", ack_b_o, 9'h000);
      cyc(256, "t4");
      chk("t4_err_early", 9'(err_o), 9'd0);
      cyc(1, "t4");
      chk("t4_err", 9'(err_o), 9'd1);
      chk("t4_idle", 9'(busy_o), 9'd0);
      pa = 0; pb = 0;
      cyc(3, "t4");
      err_clr = 1;
      cyc(1, "t4");
      err_clr = 0;

      // Async reset in the middle of an ack pulse
      pc = 1; chan = 4'd8;
      cyc(4, "t5");
      chk("t5_irq", 9'(irq_o), 9'd1);
      irq_ack = 1;
      cyc(1, "t5");
      irq_ack = 0;
      chk("t5_ack", ack_c_o, 9'h100);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_ack", ack_c_o, 9'd0);
      chk("t5_rst_busy", 9'(busy_o), 9'd0);
      chk("t5_rst_vec", 9'(irq_vec_o), 9'd0);
      cyc(1, "t5");
      rst_n = 1'b1;
      cyc(3, "t5");
      chk("t5_irq_early", 9'(irq_o), 9'd0);
      cyc(1, "t5");
      chk("t5_irq_again", 9'(irq_o), 9'd1);
      chk("t5_vec", 9'(irq_vec_o), 9'b11_1000);
      pc = 0;

      // Randomized traffic against the model
      hold = 0;
      for (int i = 0; i < 1200; i++) begin
         if (hold == 0) begin
            pa   = ($urandom_range(0, 3) == 0);
            pb   = ($urandom_range(0, 2) == 0);
            pc   = ($urandom_range(0, 1) == 0);
            chan = 4'($urandom_range(0, 10));
            hold = $urandom_range(1, 7);
         end
         hold--;
         irq_ack = ($urandom_range(0, 2) == 0);
         err_clr = ($urandom_range(0, 15) == 0);
         cyc(1, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
